// File: rtl/mmio_uart_rx.sv
// mmio_uart_rx: 8N1 UART receiver with a receive FIFO behind DATA/STATUS MMIO registers.
module mmio_uart_rx #(
  parameter int CLK_HZ = 27000000,
  parameter int BAUD = 115200,
  parameter int BASE_ADDR = 1028,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  input  logic [31:0] addr,
  input  logic [31:0] data_out,
  input  logic        mem_en,
  input  logic        mem_read,
  output logic [31:0] data_in
);
  localparam int DIV = (CLK_HZ / BAUD < 4) ? 4 : CLK_HZ / BAUD;
  localparam int CW = $clog2(DIV + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state;
  logic s1, rxs, brk, ovr, ferr;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shift;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic bit_end, stop_smp, push, ferr_set, empty, full;
  logic rd_data, rd_stat, wr_stat, pop, wr_ok;
  always_comb begin
    bit_end = cnt == CW'(DIV - 1);
    stop_smp = state == STOP && !brk && bit_end;
    push = stop_smp && rxs;
    ferr_set = stop_smp && !rxs;
    empty = wp == rp;
    full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    rd_data = mem_en && mem_read && addr == 32'(BASE_ADDR);
    rd_stat = mem_en && mem_read && addr == 32'(BASE_ADDR + 4);
    wr_stat = mem_en && !mem_read && addr == 32'(BASE_ADDR + 4);
    pop = rd_data && !empty;
    wr_ok = push && (!full || pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {uart_rx, s1};
  // brk holds STOP after a framing error until the line returns high
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      brk <= 1'b0;
    end else begin
      case (state)
        IDLE: if (!rxs) begin
          cnt <= '0;
          state <= START;
        end
        START: if (cnt == CW'(DIV / 2 - 1)) begin
          cnt <= '0;
          idx <= '0;
          state <= rxs ? IDLE : DATA;
        end else cnt <= cnt + 1'b1;
        DATA: if (bit_end) begin
          cnt <= '0;
          shift[idx] <= rxs;
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= STOP;
        end else cnt <= cnt + 1'b1;
        STOP: if (brk) begin
          if (rxs) begin
            brk <= 1'b0;
            state <= IDLE;
          end
        end else if (bit_end) begin
          cnt <= '0;
          if (rxs) state <= IDLE;
          else brk <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  always_ff @(posedge clk)
    if (wr_ok) mem[wp[AW-1:0]] <= shift;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      data_in <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      ovr <= (push && full && !pop) || (ovr && !(wr_stat && data_out[2]));
      ferr <= ferr_set || (ferr && !(wr_stat && data_out[3]));
      if (rd_data) data_in <= empty ? 32'h0 : {23'b0, 1'b1, mem[rp[AW-1:0]]};
      else if (rd_stat) data_in <= {28'b0, ferr, ovr, full, !empty};
    end
endmodule

// File: tb/tb_mmio_uart_rx.sv
// tb_mmio_uart_rx: directed scenario tests for mmio_uart_rx at DIV=16.
module tb_mmio_uart_rx;
  localparam logic [31:0] BASE = 32'd1028;
  localparam logic [31:0] STAT = 32'd1032;
  logic clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1, mem_en = 1'b0, mem_read = 1'b0;
  logic [31:0] addr = '0, data_out = '0, data_in;
  int pass = 0, total = 0;
  mmio_uart_rx #(.CLK_HZ(16), .BAUD(1), .BASE_ADDR(1028), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .addr(addr), .data_out(data_out),
    .mem_en(mem_en), .mem_read(mem_read), .data_in(data_in)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    uart_rx = 1'b1;
    mem_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask
  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic rd);
    @(posedge clk);
    #1 addr = a;
    data_out = wd;
    mem_read = rd;
    mem_en = 1'b1;
    @(posedge clk);
    #1 mem_en = 1'b0;
  endtask
  // n cycles of a 16-cycle-per-bit frame; optional bus access on cycle acc
  task automatic frame(input logic [7:0] b, input logic stop, input int n, input int acc,
                       input logic [31:0] a, input logic [31:0] wd, input logic rd);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 uart_rx = (i < 16) ? 1'b0 : (i < 144) ? b[(i - 16) / 16] : stop;
      mem_en = (i == acc);
      if (i == acc) begin
        addr = a;
        data_out = wd;
        mem_read = rd;
      end
    end
    @(posedge clk);
    #1 uart_rx = 1'b1;
    mem_en = 1'b0;
  endtask
  task automatic send(input logic [7:0] b);
    frame(b, 1'b1, 160, -1, '0, '0, 1'b1);
  endtask
  task automatic test_reset();
    do_reset();
    total++;
    if (data_in !== 32'h0) $display("FAIL reset_data_in got %h want %h", data_in, 32'h0);
    else pass++;
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL reset_status got %h want %h", data_in, 32'h0);
    else pass++;
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL reset_data_read got %h want %h", data_in, 32'h0);
    else pass++;
  endtask
  task automatic test_basic();
    do_reset();
    send(8'hA5);
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h1A5) $display("FAIL basic_a5 got %h want %h", data_in, 32'h1A5);
    else pass++;
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL basic_empty got %h want %h", data_in, 32'h0);
    else pass++;
  endtask
  task automatic test_overflow();
    logic [31:0] exp;
    do_reset();
    for (int k = 1; k <= 5; k++) send(8'(k));
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h7) $display("FAIL ovr_status got %h want %h", data_in, 32'h7);
    else pass++;
    for (int k = 1; k <= 4; k++) begin
      exp = 32'h100 + 32'(k);
      bus(BASE, 0, 1);
      total++;
      if (data_in !== exp) $display("FAIL ovr_read%0d got %h want %h", k, data_in, exp);
      else pass++;
    end
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h4) $display("FAIL ovr_after_drain got %h want %h", data_in, 32'h4);
    else pass++;
    bus(STAT, 32'h4, 0);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL ovr_clear got %h want %h", data_in, 32'h0);
    else pass++;
  endtask
  task automatic test_glitch();
    do_reset();
    @(posedge clk);
    #1 uart_rx = 1'b0;
    repeat (8) @(posedge clk);
    #1 uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL glitch_status got %h want %h", data_in, 32'h0);
    else pass++;
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL glitch_data got %h want %h", data_in, 32'h0);
    else pass++;
  endtask
  task automatic test_ferr();
    do_reset();
    frame(8'h3C, 1'b0, 160, 154, STAT, 32'h8, 1'b0);
    repeat (8) @(posedge clk);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h8) $display("FAIL ferr_set_priority got %h want %h", data_in, 32'h8);
    else pass++;
    bus(BASE, 0, 0);
    bus(32'd2000, 0, 1);
    total++;
    if (data_in !== 32'h8) $display("FAIL ignored_access got %h want %h", data_in, 32'h8);
    else pass++;
    bus(STAT, 32'h4, 0);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h8) $display("FAIL ferr_wrong_bit got %h want %h", data_in, 32'h8);
    else pass++;
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL ferr_discard got %h want %h", data_in, 32'h0);
    else pass++;
    bus(STAT, 32'h8, 0);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL ferr_clear got %h want %h", data_in, 32'h0);
    else pass++;
  endtask
  task automatic test_back_to_back();
    logic [31:0] exp;
    do_reset();
    for (int k = 1; k <= 4; k++) send(8'(k));
    frame(8'h05, 1'b1, 160, 154, BASE, '0, 1'b1);
    total++;
    if (data_in !== 32'h101) $display("FAIL same_cycle_pop got %h want %h", data_in, 32'h101);
    else pass++;
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h3) $display("FAIL same_cycle_status got %h want %h", data_in, 32'h3);
    else pass++;
    for (int k = 2; k <= 5; k++) begin
      exp = 32'h100 + 32'(k);
      bus(BASE, 0, 1);
      total++;
      if (data_in !== exp) $display("FAIL same_cycle_read%0d got %h want %h", k, data_in, exp);
      else pass++;
    end
  endtask
  task automatic test_reset_midframe();
    do_reset();
    send(8'h77);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h1) $display("FAIL mid_pre_status got %h want %h", data_in, 32'h1);
    else pass++;
    frame(8'hFF, 1'b1, 88, -1, '0, '0, 1'b1);
    #2 rst_n = 1'b0;
    #2;
    total++;
    if (data_in !== 32'h0) $display("FAIL async_reset got %h want %h", data_in, 32'h0);
    else pass++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    bus(STAT, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL mid_post_status got %h want %h", data_in, 32'h0);
    else pass++;
    send(8'h5A);
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h15A) $display("FAIL mid_5a got %h want %h", data_in, 32'h15A);
    else pass++;
    bus(BASE, 0, 1);
    total++;
    if (data_in !== 32'h0) $display("FAIL mid_no_extra got %h want %h", data_in, 32'h0);
    else pass++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_glitch();
    test_ferr();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mmio_uart_rx.md
MMIO_UART_RX -- requirements
Module: mmio_uart_rx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD, integer-truncated, minimum 4.
REQ-003 SHALL have parameter BASE_ADDR, default 1028, byte address of the DATA register; STATUS is at BASE_ADDR+4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries, a power of two, at least 2.
REQ-005 SHALL have port clk, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have port uart_rx, input, 1, asynchronous serial line that idles high.
REQ-008 SHALL have port addr, input, 32, bus byte address from the CPU.
REQ-009 SHALL have port data_out, input, 32, CPU write data.
REQ-010 SHALL have port mem_en, input, 1, bus access strobe, one cycle per access.
REQ-011 SHALL have port mem_read, input, 1; 1 means read, 0 means write.
REQ-012 SHALL have port data_in, output, 32, read data returned to the CPU.

Function
REQ-013 SHALL pass uart_rx through a 2-flop synchronizer; all receive logic uses the synchronized value rxs.
REQ-014 SHALL implement the receive FSM with states IDLE, START, DATA and STOP, plus a bit-time counter and a 3-bit bit index.
REQ-015 IDLE: when rxs is 0, clear the counter and go to START.
REQ-016 START: after DIV/2 cycles, sample rxs; if 1, treat it as a glitch and return to IDLE; if 0, go to DATA.
REQ-017 DATA: sample rxs every DIV cycles into shift bit [index], LSB first; after bit 7, go to STOP.
REQ-018 STOP: after DIV cycles, sample rxs.
  - If 1: push the byte to the FIFO and go to IDLE.
  - If 0: set FERR, discard the byte, and go to IDLE only once rxs returns to 1.
REQ-019 SHALL drop the byte and set OVR when a push occurs while the FIFO is full and no pop occurs in the same cycle.
REQ-020 SHALL perform both operations when a push and a pop occur in the same cycle while the FIFO is full; OVR is not set and the count is unchanged.
REQ-021 SHALL decode a DATA read as mem_en=1 && mem_read=1 && addr==BASE_ADDR.
  - data_in = {23'b0, valid, byte}, registered, valid on the cycle after the strobe.
  - A DATA read pops the FIFO only when it is non-empty.
REQ-022 SHALL return data_in = 0 for a DATA read while the FIFO is empty, with no pointer change.
REQ-023 SHALL decode a STATUS read at BASE_ADDR+4, returning data_in = {28'b0, FERR, OVR, full, nonempty} on the next cycle.
REQ-024 SHALL treat a write to STATUS as write-1-to-clear: data_out[2] clears OVR and data_out[3] clears FERR.
REQ-025 SHALL give a set event priority over a clear in the same cycle.
REQ-026 SHALL ignore writes to DATA, accesses to any other address, and strobes with mem_en=0; data_in holds its previous value in these cases.
REQ-027 SHALL use FIFO pointers of log2(FIFO_DEPTH)+1 bits that wrap modulo 2*FIFO_DEPTH; full is asserted when the pointers differ only in their MSB.

Reset
REQ-028 SHALL, while rst_n=0, immediately set:
  - FSM to IDLE, counters and pointers to 0;
  - FIFO empty;
  - OVR and FERR to 0;
  - data_in to 0;
  - synchronizer flops to 1.
REQ-029 SHALL abandon any partial frame on reset; after release, the FSM waits for a new falling edge of rxs.

Verification
REQ-030 With CLK_HZ=16 and BAUD=1 (DIV=16), send 0xA5 8N1, then read BASE_ADDR -> data_in=0x1A5; a following read -> 0x000.
REQ-031 Send 0x01, 0x02, 0x03, 0x04, 0x05 with no reads -> STATUS=0x7; four DATA reads return 0x101, 0x102, 0x103, 0x104; then STATUS=0x4.
REQ-032 Hold uart_rx low for 8 cycles, then high -> FSM returns to IDLE, FIFO stays empty, STATUS=0x0.
REQ-033 Send 0x3C with the stop bit forced to 0 -> STATUS=0x8; write 0x8 to BASE_ADDR+4 -> STATUS=0x0.
REQ-034 With the FIFO full, issue a DATA read in the same cycle as a stop-bit push -> OVR stays 0 and STATUS=0x3.
REQ-035 Assert rst_n=0 mid-frame at bit 4, release, then send 0x5A -> the single read returns 0x15A and no corrupted byte is present.
